// File: rtl/arm_bus_pkg.sv
// Shared definitions for the CS5 bus initiator and its register-file responder:
// bus widths, default cycle timing, FSM states and the timeout data marker.
package arm_bus_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam int SETUP_CYC_DEF   = 2;
    localparam int STROBE_CYC_DEF  = 3;
    localparam int HOLD_CYC_DEF    = 1;
    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int CNT_W_DEF       = 8;

    localparam logic [DATA_W-1:0] DEAD_DATA = 32'hDEAD_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } bus_state_e;

    // A read or write strobe is low in both the timed strobe phase and the stretch phase.
    function automatic logic strobe_phase(input bus_state_e st);
        return (st == ST_STROBE) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/arm_bus_master_if.sv
// Request/response handshake plus CS5 bus pins of the bus initiator.
// The master modport is the initiator's view; slave is the requester/responder side.
interface arm_bus_master_if;
    import arm_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be_n;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] bus_addr;
    logic [BE_W-1:0]   bus_be_n;
    logic [DATA_W-1:0] bus_dout;
    logic              bus_dout_oe;
    logic [DATA_W-1:0] bus_din;
    logic              bus_as;
    logic              bus_rs_n;
    logic              bus_ws_n;
    logic              bus_wait;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_be_n, bus_din, bus_wait,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_addr, bus_be_n, bus_dout, bus_dout_oe, bus_as, bus_rs_n, bus_ws_n
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_be_n, bus_din, bus_wait,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_addr, bus_be_n, bus_dout, bus_dout_oe, bus_as, bus_rs_n, bus_ws_n
    );

endinterface

// File: rtl/arm_bus_master.sv
// CS5 bus initiator: turns single-beat fabric requests into timed as/rs_n/ws_n
// bus cycles and returns a one-cycle response with captured read data.
module arm_bus_master
    import arm_bus_pkg::*;
#(
    parameter int SETUP_CYC   = SETUP_CYC_DEF,
    parameter int STROBE_CYC  = STROBE_CYC_DEF,
    parameter int HOLD_CYC    = HOLD_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    arm_bus_master_if.master    bus
);

    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

    bus_state_e        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              accept_s, capture_s, timeout_s, done_s, write_s;

    logic              write_r;
    logic              err_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [BE_W-1:0]   bus_be_n_r;
    logic [DATA_W-1:0] bus_dout_r;
    logic              bus_dout_oe_r;
    logic              bus_as_r;
    logic              bus_rs_n_r;
    logic              bus_ws_n_r;

    // Next-state and phase counter: the counter is reloaded with the phase length on every state entry.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        timeout_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_SETUP;
                    cnt_s    = SETUP_LOAD;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_SETUP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_STROBE;
                    cnt_s   = STROBE_LOAD;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_STROBE: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (bus.bus_wait) begin
                    state_s = ST_WAIT;
                    cnt_s   = TIMEOUT_LOAD;
                end else begin
                    capture_s = 1'b1;
                    state_s   = ST_HOLD;
                    cnt_s     = HOLD_LOAD;
                end
            end
            ST_WAIT: begin
                if (!bus.bus_wait) begin
                    capture_s = 1'b1;
                    state_s   = ST_HOLD;
                    cnt_s     = HOLD_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    timeout_s = 1'b1;
                    state_s   = ST_HOLD;
                    cnt_s     = HOLD_LOAD;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        write_s = accept_s ? bus.req_write : write_r;
    end

    // FSM state and phase counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Bus pins and response are all derived from the next state so nothing reaches the pins combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r       <= 1'b0;
            err_r         <= 1'b0;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            bus_addr_r    <= {ADDR_W{1'b0}};
            bus_be_n_r    <= {BE_W{1'b1}};
            bus_dout_r    <= {DATA_W{1'b0}};
            bus_dout_oe_r <= 1'b0;
            bus_as_r      <= 1'b0;
            bus_rs_n_r    <= 1'b1;
            bus_ws_n_r    <= 1'b1;
        end else begin
            if (accept_s) begin
                write_r    <= bus.req_write;
                bus_addr_r <= bus.req_addr;
                bus_be_n_r <= bus.req_be_n;
                bus_dout_r <= bus.req_wdata;
            end
            if (accept_s) begin
                err_r <= 1'b0;
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end
            if (timeout_s) begin
                rsp_rdata_r <= DEAD_DATA;
            end else if (capture_s) begin
                rsp_rdata_r <= write_r ? {DATA_W{1'b0}} : bus.bus_din;
            end
            req_ready_r   <= (state_s == ST_IDLE);
            rsp_valid_r   <= done_s;
            rsp_err_r     <= done_s && err_r;
            bus_as_r      <= (state_s != ST_IDLE);
            bus_dout_oe_r <= (state_s != ST_IDLE) && write_s;
            bus_rs_n_r    <= !(strobe_phase(state_s) && !write_s);
            bus_ws_n_r    <= !(strobe_phase(state_s) && write_s);
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.bus_addr    = bus_addr_r;
    assign bus.bus_be_n    = bus_be_n_r;
    assign bus.bus_dout    = bus_dout_r;
    assign bus.bus_dout_oe = bus_dout_oe_r;
    assign bus.bus_as      = bus_as_r;
    assign bus.bus_rs_n    = bus_rs_n_r;
    assign bus.bus_ws_n    = bus_ws_n_r;

endmodule

// File: tb/tb_arm_bus_master.sv
// Directed bench for arm_bus_master with a small behavioural register responder
// on the bus pins; expected cycle-by-cycle values are hand-derived from the timing.
module tb_arm_bus_master;
    import arm_bus_pkg::*;

    logic clk;
    logic rst;
    int   check_cnt;
    int   pass_cnt;
    int   fail_cnt;

    logic [31:0] mem [0:15];
    logic        din_force;
    logic [31:0] din_val;

    arm_bus_master_if bif ();

    arm_bus_master #(
        .SETUP_CYC   (2),
        .STROBE_CYC  (3),
        .HOLD_CYC    (1),
        .TIMEOUT_CYC (8),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: stores on a write strobe, returns stored word unless the bench forces read data.
    always @(posedge clk) begin
        if (bif.bus_as && !bif.bus_ws_n) mem[bif.bus_addr[3:0]] <= bif.bus_dout;
    end
    assign bif.bus_din = din_force ? din_val : mem[bif.bus_addr[3:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic wr, input logic [23:0] addr, input logic [31:0] wdata);
        bif.req_valid = 1'b1;
        bif.req_write = wr;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        bif.req_be_n  = 4'b0000;
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        din_force     = 1'b0;
        din_val       = 32'h0;
        rst           = 1'b1;
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_addr  = 24'h0;
        bif.req_wdata = 32'h0;
        bif.req_be_n  = 4'hF;
        bif.bus_wait  = 1'b0;
        cyc();
        cyc();

        chk("rst req_ready", {31'h0, bif.req_ready}, 32'h1);
        chk("rst rsp_valid", {31'h0, bif.rsp_valid}, 32'h0);
        chk("rst rsp_rdata", bif.rsp_rdata, 32'h0);
        chk("rst as", {31'h0, bif.bus_as}, 32'h0);
        chk("rst rs_n/ws_n/oe", {29'h0, bif.bus_rs_n, bif.bus_ws_n, bif.bus_dout_oe}, 32'h6);
        chk("rst be_n", {28'h0, bif.bus_be_n}, 32'hF);
        chk("rst addr", {8'h0, bif.bus_addr}, 32'h0);
        rst = 1'b0;
        cyc();

        // Write 0x10 <- DEADBEEF accepted in T0
        present(1'b1, 24'h000010, 32'hDEADBEEF);
        cyc();
        bif.req_valid = 1'b0;
        chk("wr addr", {8'h0, bif.bus_addr}, 32'h10);
        chk("wr dout", bif.bus_dout, 32'hDEADBEEF);
        chk("wr be_n", {28'h0, bif.bus_be_n}, 32'h0);
        for (int t = 1; t <= 8; t++) begin
            chk($sformatf("wr as T%0d", t), {31'h0, bif.bus_as}, {31'h0, (t <= 6)});
            chk($sformatf("wr oe T%0d", t), {31'h0, bif.bus_dout_oe}, {31'h0, (t <= 6)});
            chk($sformatf("wr ws_n T%0d", t), {31'h0, bif.bus_ws_n}, {31'h0, !(t >= 3 && t <= 5)});
            chk($sformatf("wr rs_n T%0d", t), {31'h0, bif.bus_rs_n}, 32'h1);
            chk($sformatf("wr rsp_valid T%0d", t), {31'h0, bif.rsp_valid}, {31'h0, (t == 7)});
            chk($sformatf("wr ready T%0d", t), {31'h0, bif.req_ready}, {31'h0, (t >= 7)});
            if (t == 7) begin
                chk("wr rsp_err", {31'h0, bif.rsp_err}, 32'h0);
                chk("wr rsp_rdata", bif.rsp_rdata, 32'h0);
            end
            cyc();
        end

        // Loopback read of 0x10
        present(1'b0, 24'h000010, 32'h0);
        cyc();
        bif.req_valid = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            chk($sformatf("rd rs_n T%0d", t), {31'h0, bif.bus_rs_n}, {31'h0, !(t >= 3 && t <= 5)});
            chk($sformatf("rd ws_n/oe T%0d", t), {30'h0, bif.bus_ws_n, bif.bus_dout_oe}, 32'h2);
            if (t == 7) begin
                chk("rd rsp_valid", {31'h0, bif.rsp_valid}, 32'h1);
                chk("rd rsp_rdata", bif.rsp_rdata, 32'hDEADBEEF);
                chk("rd rsp_err", {31'h0, bif.rsp_err}, 32'h0);
            end
            cyc();
        end
        chk("rd rdata held", bif.rsp_rdata, 32'hDEADBEEF);

        // Read stretched by 4 wait cycles; data appears as wait drops
        din_force    = 1'b1;
        din_val      = 32'hAAAA5555;
        bif.bus_wait = 1'b1;
        present(1'b0, 24'h000020, 32'h0);
        cyc();
        bif.req_valid = 1'b0;
        for (int t = 1; t <= 11; t++) begin
            if (t == 9) begin
                bif.bus_wait = 1'b0;
                din_val      = 32'h12345678;
            end
            chk($sformatf("wt rs_n T%0d", t), {31'h0, bif.bus_rs_n}, {31'h0, !(t >= 3 && t <= 9)});
            chk($sformatf("wt as T%0d", t), {31'h0, bif.bus_as}, {31'h0, (t <= 10)});
            chk($sformatf("wt rsp_valid T%0d", t), {31'h0, bif.rsp_valid}, {31'h0, (t == 11)});
            if (t == 11) begin
                chk("wt rsp_rdata", bif.rsp_rdata, 32'h12345678);
                chk("wt rsp_err", {31'h0, bif.rsp_err}, 32'h0);
            end
            cyc();
        end

        // Wait stuck high: timeout after 8 stretch cycles
        bif.bus_wait = 1'b1;
        present(1'b0, 24'h000030, 32'h0);
        cyc();
        bif.req_valid = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            chk($sformatf("to rs_n T%0d", t), {31'h0, bif.bus_rs_n}, {31'h0, !(t >= 3 && t <= 13)});
            chk($sformatf("to as T%0d", t), {31'h0, bif.bus_as}, {31'h0, (t <= 14)});
            chk($sformatf("to rsp_valid T%0d", t), {31'h0, bif.rsp_valid}, {31'h0, (t == 15)});
            chk($sformatf("to rsp_err T%0d", t), {31'h0, bif.rsp_err}, {31'h0, (t == 15)});
            if (t == 15) chk("to rsp_rdata", bif.rsp_rdata, 32'hDEAD0000);
            cyc();
        end
        bif.bus_wait = 1'b0;
        din_force    = 1'b0;

        // Back to back: write 0x01 <- 0x11 then read 0x01, request held until accepted
        present(1'b1, 24'h000001, 32'h00000011);
        cyc();
        present(1'b0, 24'h000001, 32'h0);
        for (int t = 1; t <= 15; t++) begin
            chk($sformatf("bb as T%0d", t), {31'h0, bif.bus_as}, {31'h0, (t != 7 && t <= 13)});
            chk($sformatf("bb rsp_valid T%0d", t), {31'h0, bif.rsp_valid}, {31'h0, (t == 7 || t == 14)});
            chk($sformatf("bb ready T%0d", t), {31'h0, bif.req_ready}, {31'h0, (t == 7 || t >= 14)});
            chk($sformatf("bb ws_n T%0d", t), {31'h0, bif.bus_ws_n}, {31'h0, !(t >= 3 && t <= 5)});
            chk($sformatf("bb rs_n T%0d", t), {31'h0, bif.bus_rs_n}, {31'h0, !(t >= 10 && t <= 12)});
            if (t == 14) chk("bb rsp_rdata", bif.rsp_rdata, 32'h00000011);
            cyc();
            if (t == 7) bif.req_valid = 1'b0;
        end

        // Reset during the write strobe
        present(1'b1, 24'h000002, 32'hCAFEF00D);
        cyc();
        bif.req_valid = 1'b0;
        cyc();
        cyc();
        chk("rs ws_n low T3", {31'h0, bif.bus_ws_n}, 32'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rs ws_n", {31'h0, bif.bus_ws_n}, 32'h1);
        chk("rs as", {31'h0, bif.bus_as}, 32'h0);
        chk("rs oe", {31'h0, bif.bus_dout_oe}, 32'h0);
        chk("rs ready", {31'h0, bif.req_ready}, 32'h1);
        for (int t = 0; t < 6; t++) begin
            chk($sformatf("rs rsp_valid +%0d", t), {31'h0, bif.rsp_valid}, 32'h0);
            chk($sformatf("rs as +%0d", t), {31'h0, bif.bus_as}, 32'h0);
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
